// File: rtl/tensor_cpu_pkg.sv
// Shared opcodes, flag bit positions, matmul FSM states and the wrap/saturate helper.
package tensor_cpu_pkg;

  localparam logic [7:0] OP_ADD        = 8'h00;
  localparam logic [7:0] OP_SUB        = 8'h01;
  localparam logic [7:0] OP_MUL        = 8'h02;
  localparam logic [7:0] OP_EQL        = 8'h03;
  localparam logic [7:0] OP_GRT        = 8'h04;
  localparam logic [7:0] OP_TC_OPERATE = 8'h05;
  localparam logic [7:0] OP_TC_LOAD    = 8'h06;
  localparam logic [7:0] OP_CPU_TO_TC  = 8'h07;
  localparam logic [7:0] OP_NOP        = 8'h08;
  localparam logic [7:0] OP_ADD_IMM    = 8'h09;
  localparam logic [7:0] OP_SUB_IMM    = 8'h0A;
  localparam logic [7:0] OP_MOVE_CPU   = 8'h0B;
  localparam logic [7:0] OP_MOVE_TC    = 8'h0C;
  localparam logic [7:0] OP_RESET      = 8'h0D;
  localparam logic [7:0] OP_TC_TO_CPU  = 8'h0E;
  localparam logic [7:0] OP_READ_CPU   = 8'h0F;
  localparam logic [7:0] OP_READ_TC    = 8'h10;

  localparam int ST_PARITY = 4;
  localparam int ST_OVF    = 3;
  localparam int ST_CARRY  = 2;
  localparam int ST_ZERO   = 1;
  localparam int ST_SIGN   = 0;

  typedef enum logic [1:0] {IDLE, MAC, COMMIT} tc_state_t;

  // Clamps v to the signed w-bit range when sat is set; otherwise the caller's
  // truncation to w bits provides the wrap.
  function automatic logic signed [63:0] fit_width(input logic signed [63:0] v,
                                                   input int unsigned w,
                                                   input logic sat);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (sat && v > hi) return hi;
    if (sat && v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/tensor_matmul_sequencer.sv
// Sequential C = A x B, one MAC per cycle (k innermost), results held in a private buffer.
// Latency N^3 MAC cycles plus one COMMIT cycle; start is only honoured in IDLE.
module tensor_matmul_sequencer
  import tensor_cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MATRIX_DIM = 4,
  parameter int SATURATE   = 0
) (
  input  logic                                           clock_in,
  input  logic                                           reset_in,
  input  logic                                           start,
  input  logic [2*MATRIX_DIM*MATRIX_DIM*DATA_WIDTH-1:0]  tf_flat,
  output logic                                           busy,
  output logic                                           commit,
  output logic [MATRIX_DIM*MATRIX_DIM*DATA_WIDTH-1:0]    buf_flat
);

  localparam int N  = MATRIX_DIM;
  localparam int NN = N * N;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int AW = 2 * DATA_WIDTH + CW;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  tc_state_t                      state;
  logic [CW-1:0]                  i, j, k;
  logic signed [AW-1:0]           acc;
  logic [NN*DATA_WIDTH-1:0]       buf_q;

  int                             a_idx, b_idx, wr_idx;
  logic signed [DATA_WIDTH-1:0]   a_el, b_el;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [AW-1:0]           sum;
  logic signed [63:0]             fitted;

  always_comb begin
    a_idx  = int'(i) * N + int'(k);
    b_idx  = NN + int'(k) * N + int'(j);
    wr_idx = int'(i) * N + int'(j);
    a_el   = tf_flat[a_idx*DATA_WIDTH +: DATA_WIDTH];
    b_el   = tf_flat[b_idx*DATA_WIDTH +: DATA_WIDTH];
    prod   = a_el * b_el;
    sum    = acc + AW'(prod);
    fitted = fit_width(64'(sum), DATA_WIDTH, SATURATE != 0);
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state <= IDLE;
      i     <= '0;
      j     <= '0;
      k     <= '0;
      acc   <= '0;
      buf_q <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= MAC;
          i     <= '0;
          j     <= '0;
          k     <= '0;
          acc   <= '0;
        end
        MAC: if (k == LAST) begin
          buf_q[wr_idx*DATA_WIDTH +: DATA_WIDTH] <= fitted[DATA_WIDTH-1:0];
          acc <= '0;
          k   <= '0;
          if (j == LAST) begin
            j <= '0;
            if (i == LAST) begin
              i     <= '0;
              state <= COMMIT;
            end else begin
              i <= i + CW'(1);
            end
          end else begin
            j <= j + CW'(1);
          end
        end else begin
          acc <= sum;
          k   <= k + CW'(1);
        end
        COMMIT:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy     = (state != IDLE);
  assign commit   = (state == COMMIT);
  assign buf_flat = buf_q;

endmodule

// File: rtl/tensor_cpu.sv
// Scalar ALU + scalar/tensor register files with a sequential matmul engine; 1-cycle result latency.
// instruction_ready_out drops for the N^3+1 cycles of a tensor multiply; held instructions wait.
module tensor_cpu
  import tensor_cpu_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_CPU_REGS = 32,
  parameter int MATRIX_DIM   = 4,
  parameter int SATURATE     = 0
) (
  input  logic                         clock_in,
  input  logic                         reset_in,
  input  logic [31:0]                  instruction_in,
  input  logic                         instruction_valid_in,
  output logic                         instruction_ready_out,
  output logic signed [DATA_WIDTH-1:0] cpu_output,
  output logic                         cpu_output_valid_out,
  output logic                         busy_out,
  output logic [4:0]                   status_out
);

  localparam int NN = MATRIX_DIM * MATRIX_DIM;
  localparam int TS = 2 * NN;
  localparam int TA = $clog2(TS);
  localparam int RW = (NUM_CPU_REGS > 1) ? $clog2(NUM_CPU_REGS) : 1;
  localparam int DW = DATA_WIDTH;

  logic signed [DW-1:0] rf [NUM_CPU_REGS];
  logic signed [DW-1:0] tf [TS];

  logic [7:0] dest, src1, src2, opcode;
  logic [TA-1:0] t_dest, t_src;
  logic dest_ok, t_dest_ok, accept, busy, commit;
  logic signed [DW-1:0] opa, opb, tf_rd, alu_res;
  logic [DW:0] u_sum, u_diff;
  logic [2*DW-1:0] u_prod;
  logic signed [2*DW-1:0] s_prod;
  logic signed [63:0] wide, fitted;
  logic is_alu, alu_ovf, alu_cy;
  logic [TS*DW-1:0] tf_flat;
  logic [NN*DW-1:0] buf_flat;

  assign {dest, src1, src2, opcode} = instruction_in;
  assign t_dest    = dest[TA-1:0];
  assign t_src     = src1[TA-1:0];
  assign dest_ok   = 32'(dest) < NUM_CPU_REGS;
  assign t_dest_ok = 32'(t_dest) < TS;

  assign instruction_ready_out = !busy && !reset_in;
  assign accept   = instruction_valid_in && instruction_ready_out;
  assign busy_out = busy;

  always_comb begin
    tf_flat = '0;
    for (int n = 0; n < TS; n++) tf_flat[n*DW +: DW] = tf[n];
  end

  tensor_matmul_sequencer #(
    .DATA_WIDTH(DATA_WIDTH), .MATRIX_DIM(MATRIX_DIM), .SATURATE(SATURATE)
  ) u_seq (
    .clock_in(clock_in), .reset_in(reset_in),
    .start(accept && opcode == OP_TC_OPERATE),
    .tf_flat(tf_flat), .busy(busy), .commit(commit), .buf_flat(buf_flat)
  );

  always_comb begin
    opa    = (32'(src1) < NUM_CPU_REGS) ? rf[src1[RW-1:0]] : '0;
    opb    = (32'(src2) < NUM_CPU_REGS) ? rf[src2[RW-1:0]] : '0;
    if (opcode == OP_ADD_IMM || opcode == OP_SUB_IMM) opb = DW'($signed(src2));
    tf_rd  = (32'(t_src) < TS) ? tf[t_src] : '0;
    u_sum  = {1'b0, opa} + {1'b0, opb};
    u_diff = {1'b0, opa} - {1'b0, opb};
    u_prod = $unsigned(opa) * $unsigned(opb);
    s_prod = opa * opb;
    is_alu = 1'b1;
    alu_cy = 1'b0;
    wide   = '0;
    case (opcode)
      OP_ADD, OP_ADD_IMM: begin wide = 64'(opa) + 64'(opb); alu_cy = u_sum[DW];  end
      OP_SUB, OP_SUB_IMM: begin wide = 64'(opa) - 64'(opb); alu_cy = u_diff[DW]; end
      OP_MUL:      begin wide = 64'(s_prod); alu_cy = |u_prod[2*DW-1:DW]; end
      OP_EQL:      wide = {63'd0, opa == opb};
      OP_GRT:      wide = {63'd0, opa > opb};
      OP_MOVE_CPU: wide = 64'(opa);
      default:     is_alu = 1'b0;
    endcase
    // Overflow is judged on the exact result, independent of the wrap/saturate choice.
    fitted  = fit_width(wide, DW, SATURATE != 0);
    alu_res = fitted[DW-1:0];
    alu_ovf = fit_width(wide, DW, 1'b1) != wide;
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      for (int n = 0; n < NUM_CPU_REGS; n++) rf[n] <= '0;
      for (int n = 0; n < TS; n++) tf[n] <= '0;
      status_out           <= '0;
      cpu_output           <= '0;
      cpu_output_valid_out <= 1'b0;
    end else begin
      cpu_output_valid_out <= 1'b0;
      if (commit)
        for (int n = 0; n < NN; n++) tf[n] <= buf_flat[n*DW +: DW];
      if (accept) begin
        if (is_alu) begin
          if (dest_ok) rf[dest[RW-1:0]] <= alu_res;
          cpu_output           <= alu_res;
          cpu_output_valid_out <= 1'b1;
          status_out[ST_PARITY] <= ^alu_res;
          status_out[ST_OVF]    <= alu_ovf;
          status_out[ST_CARRY]  <= alu_cy;
          status_out[ST_ZERO]   <= (alu_res == '0);
          status_out[ST_SIGN]   <= alu_res[DW-1];
        end
        case (opcode)
          OP_READ_CPU: begin cpu_output <= opa;   cpu_output_valid_out <= 1'b1; end
          OP_READ_TC:  begin cpu_output <= tf_rd; cpu_output_valid_out <= 1'b1; end
          OP_TC_TO_CPU: if (dest_ok)   rf[dest[RW-1:0]] <= tf_rd;
          OP_TC_LOAD:   if (t_dest_ok) tf[t_dest] <= DW'($signed(src1));
          OP_CPU_TO_TC: if (t_dest_ok) tf[t_dest] <= opa;
          OP_MOVE_TC:   if (t_dest_ok) tf[t_dest] <= tf_rd;
          OP_RESET: begin
            for (int n = 0; n < NUM_CPU_REGS; n++) rf[n] <= '0;
            for (int n = 0; n < TS; n++) tf[n] <= '0;
            status_out <= '0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
